ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Parametrised PS/2 keyboard receiver and key-state decoder. It replaces the fixed ps2 paddle receiver. Runs entirely on the system clock with a synchronous reset. It validates full 11-bit frames (start, data, parity, stop), recovers from stalled frames by timeout, and decodes E0/F0 prefixes into make/break events. It also tracks the held/released state of NUM_KEYS configurable keys, which drive game controls such as paddle up/down and the debug LEDs.

## Interface
- FILTER_LEN, 8: consecutive equal samples needed before the filtered PS/2 clock changes (1..255).
- TIMEOUT_CYCLES, 50000: idle clocks inside a frame before it is abandoned (≥ FILTER_LEN+4).
- NUM_KEYS, 2: number of tracked keys (1..16).
- KEY_CODES, {8'h75,8'h72}: packed NUM_KEYS×8 scan codes; key i is bits [8i+7:8i].
- KEY_EXT, 2'b11: per-key flag; 1 = key requires the E0 prefix.
- clock  in  1  system clock (50 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- PS2_CLK_in  in  1  raw PS/2 clock (asynchronous).
- PS2_DAT_in  in  1  raw PS/2 data (asynchronous).
- scancode  out  8  last completed non-prefix code (held).
- code_valid  out  1  one-cycle pulse; scancode/code_ext/code_break valid.
- code_ext  out  1  E0 preceded the code.
- code_break  out  1  F0 preceded the code (release).
- key_state  out  NUM_KEYS  1 = key i currently held.
- frame_error  out  1  one-cycle pulse on a parity, stop or timeout error.

## Operation
- Input path: each line passes through a 2-flop synchroniser, then a glitch filter. The filtered value flips only after FILTER_LEN consecutive samples that differ from it. Data is sampled from its synchronised value.
- A falling edge of the filtered clock is a "bit event".
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a bit event with data=0, go to DATA with bit count 0. With data=1, stay in IDLE and raise no error.
  - DATA: shift data LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: if data=1 and parity is OK, the byte is accepted. Otherwise pulse frame_error. Go to IDLE in either case.
- Timeout: the idle counter resets on every bit event. In any state other than IDLE, if the counter reaches TIMEOUT_CYCLES, go to IDLE and pulse frame_error. If a bit event and expiry occur in the same cycle, the bit event wins.
- Byte handling:
  - Byte E0 sets the ext flag. Byte F0 sets the brk flag. Neither emits code_valid.
  - Any other byte: scancode ← byte, code_ext ← ext, code_break ← brk, pulse code_valid, then clear both flags.
  - Key i updates when (byte == KEY_CODES[i] && ext == KEY_EXT[i]). It is set to 1 on make and to 0 on break. Repeated makes (typematic) leave it at 1.
- A frame error clears the ext and brk flags. key_state is unchanged.
- Reset:
  - All outputs are 0, the FSM is in IDLE, and the flags, counters and shift register are cleared.
  - The filter outputs reset to 1 (bus idle).
  - A reset mid-frame discards that frame. Subsequent bits are resynchronised via the start-bit check.

## Timing
- Bit-event latency: 2 synchroniser cycles + FILTER_LEN cycles after the raw falling edge.
- code_valid, scancode, code_ext, code_break and key_state all update 1 clock after the stop-bit event.
- frame_error asserts 1 clock after the stop-bit event or the timeout expiry.
- Only a single byte is buffered. The minimum PS/2 frame spacing (~1 ms) far exceeds the processing latency, so no back-pressure exists.
- scancode, code_ext and code_break hold their values until the next code_valid.

## Configuration
- PS2_PARITY_CHECK_EN defined: the byte is accepted only if the 8 data bits plus the parity bit have odd parity. A mismatch pulses frame_error and discards the byte.
- Undefined: the parity bit is sampled and ignored. Only the stop bit and timeout produce errors.

## Test plan
- Make down-arrow (E0, 72) with valid frames → one code_valid, scancode=72, code_ext=1, code_break=0; key_state=2'b01.
- Break (E0, F0, 72) after that → code_valid once, code_break=1, code_ext=1; key_state=2'b00. Plain 72 without E0 leaves key_state unchanged.
- Frame 1C with wrong parity, macro defined → frame_error pulse, no code_valid. Macro undefined → code_valid, scancode=1C.
- Send the start bit plus 5 data bits, then stall → frame_error exactly TIMEOUT_CYCLES clocks after the last bit event. A following valid frame (F0 → then 1C) decodes with code_break=1.
- Raw clock glitch low for FILTER_LEN−1 cycles while idle → no bit event and no state change. A glitch of FILTER_LEN cycles is accepted as an edge.
- Assert reset during DATA with key_state=2'b11 → all outputs 0 on the next clock. A complete frame 75 with E0 then sets key_state[1]=1.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Decoded key-event bus between the PS/2 decoder and its consumers.
// Latency: none, wires only.
// Backpressure: none, consumers must take code_valid/frame_error pulses as they come.
// Ports: scancode/code_ext/code_break (held code), code_valid (pulse),
//        key_state (held/released per tracked key), frame_error (pulse).
interface ps2_key_decoder_if #(
  parameter int NUM_KEYS = 2
);
  logic [7:0]          scancode;
  logic                code_valid;
  logic                code_ext;
  logic                code_break;
  logic [NUM_KEYS-1:0] key_state;
  logic                frame_error;

  modport master (
    output scancode, code_valid, code_ext, code_break, key_state, frame_error
  );

  modport slave (
    input scancode, code_valid, code_ext, code_break, key_state, frame_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frame check, E0/F0 prefix decode, held-key tracking.
// Latency: raw clock fall -> bit event 2+FILTER_LEN cycles; stop bit -> outputs 1 cycle.
// Backpressure: none, a single byte is held and frames are far slower than decode.
// Ports: clock, reset (sync, active-high), PS2_CLK_in/PS2_DAT_in (raw, async),
//        key_bus (master side of ps2_key_decoder_if).
// Option: define PS2_PARITY_CHECK_EN to reject bytes whose odd parity fails.
module ps2_key_decoder #(
  parameter int                    FILTER_LEN     = 8,
  parameter int                    TIMEOUT_CYCLES = 50000,
  parameter int                    NUM_KEYS       = 2,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h75, 8'h72},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 2'b11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PS2_CLK_in,
  input  logic             PS2_DAT_in,
  ps2_key_decoder_if.master key_bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic                clk_s1, clk_s2, dat_s1, dat_s2;
  logic                clk_filt;
  logic [FW-1:0]       filt_cnt;
  logic [TW-1:0]       idle_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift_reg;
  logic                ext_flag, brk_flag;
  logic                bit_evt, timeout, parity_ok;
  logic [7:0]          scancode_q;
  logic                code_valid_q, code_ext_q, code_break_q, frame_error_q;
  logic [NUM_KEYS-1:0] key_state_q;

`ifdef PS2_PARITY_CHECK_EN
  logic                parity_bit;
  assign parity_ok = ^{shift_reg, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Bit event fires in the cycle the filtered clock is about to fall.
  assign bit_evt = clk_filt & ~clk_s2 & (filt_cnt == FW'(FILTER_LEN - 1));
  // A bit event in the same cycle as expiry takes priority.
  assign timeout = (state != IDLE) && !bit_evt && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      clk_s1        <= 1'b1;
      clk_s2        <= 1'b1;
      dat_s1        <= 1'b1;
      dat_s2        <= 1'b1;
      clk_filt      <= 1'b1;
      filt_cnt      <= '0;
      idle_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      ext_flag      <= 1'b0;
      brk_flag      <= 1'b0;
      scancode_q    <= '0;
      code_valid_q  <= 1'b0;
      code_ext_q    <= 1'b0;
      code_break_q  <= 1'b0;
      frame_error_q <= 1'b0;
      key_state_q   <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      code_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      clk_s1 <= PS2_CLK_in;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT_in;
      dat_s2 <= dat_s1;

      // Filter: follow the synchronised clock only after FILTER_LEN differing samples.
      if (clk_s2 != clk_filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end

      if (bit_evt || state == IDLE) idle_cnt <= '0;
      else                          idle_cnt <= idle_cnt + TW'(1);

      if (timeout) begin
        state         <= IDLE;
        frame_error_q <= 1'b1;
        ext_flag      <= 1'b0;
        brk_flag      <= 1'b0;
      end else if (bit_evt) begin
        case (state)
          IDLE: begin
            // A high "start" bit means we are out of step; wait for a real start.
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {dat_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_bit <= dat_s2;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && parity_ok) begin
              if (shift_reg == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shift_reg == 8'hF0) begin
                brk_flag <= 1'b1;
              end else begin
                scancode_q   <= shift_reg;
                code_ext_q   <= ext_flag;
                code_break_q <= brk_flag;
                code_valid_q <= 1'b1;
                ext_flag     <= 1'b0;
                brk_flag     <= 1'b0;
                for (int i = 0; i < NUM_KEYS; i++) begin
                  if (shift_reg == KEY_CODES[8*i +: 8] && ext_flag == KEY_EXT[i])
                    key_state_q[i] <= ~brk_flag;
                end
              end
            end else begin
              frame_error_q <= 1'b1;
              ext_flag      <= 1'b0;
              brk_flag      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign key_bus.scancode    = scancode_q;
  assign key_bus.code_valid  = code_valid_q;
  assign key_bus.code_ext    = code_ext_q;
  assign key_bus.code_break  = code_break_q;
  assign key_bus.key_state   = key_state_q;
  assign key_bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: expected events are queued as frames are sent
// and popped by a monitor when code_valid or frame_error pulses.
module tb_ps2_key_decoder;
  localparam int FL = 4;
  localparam int TO = 200;
  localparam int H  = 20;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  ps2_key_decoder_if #(.NUM_KEYS(2)) bus ();

  ps2_key_decoder #(
    .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .NUM_KEYS(2),
    .KEY_CODES(16'h7572), .KEY_EXT(2'b11)
  ) dut (
    .clock(clock), .reset(reset), .PS2_CLK_in(ps2_clk), .PS2_DAT_in(ps2_dat),
    .key_bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Send the first n bits of a frame; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      ps2_dat = bits[b];
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    cyc(H);
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(frame(d, 1'b0), 11);
  endtask

  task automatic push_code(input logic [7:0] c, input logic e, input logic b);
    exp_t x;
    x.is_err = 1'b0; x.code = c; x.ext = e; x.brk = b;
    exp_q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.is_err = 1'b1; x.code = 8'h00; x.ext = 1'b0; x.brk = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_scancode"}, bus.scancode, 0);
    chk({tag, "_valid"}, bus.code_valid, 0);
    chk({tag, "_ext"}, bus.code_ext, 0);
    chk({tag, "_break"}, bus.code_break, 0);
    chk({tag, "_keys"}, bus.key_state, 0);
    chk({tag, "_ferr"}, bus.frame_error, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset && (bus.code_valid || bus.frame_error)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {bus.code_valid, bus.frame_error}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_kind", bus.frame_error, e.is_err);
        if (!e.is_err) begin
          chk("scancode", bus.scancode, e.code);
          chk("code_ext", bus.code_ext, e.ext);
          chk("code_break", bus.code_break, e.brk);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    logic [10:0] fb;

    // Reset state
    cyc(5);
    chk_all_zero("reset");
    reset = 1'b0;
    cyc(10);

    // Make down-arrow
    push_code(8'h72, 1'b1, 1'b0);
    send(8'hE0); send(8'h72);
    chk("make_down_keys", bus.key_state, 2'b01);

    // Break down-arrow
    push_code(8'h72, 1'b1, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h72);
    chk("break_down_keys", bus.key_state, 2'b00);

    // Make again, then a non-extended break must not release it
    push_code(8'h72, 1'b1, 1'b0);
    send(8'hE0); send(8'h72);
    push_code(8'h72, 1'b1, 1'b0);
    send(8'hE0); send(8'h72);
    chk("typematic_keys", bus.key_state, 2'b01);
    push_code(8'h72, 1'b0, 1'b1);
    send(8'hF0); send(8'h72);
    chk("plain_break_keys", bus.key_state, 2'b01);

    // Bad parity
`ifdef PS2_PARITY_CHECK_EN
    push_err();
`else
    push_code(8'h1C, 1'b0, 1'b0);
`endif
    send_bits(frame(8'h1C, 1'b1), 11);
    chk("bad_parity_drain", exp_q.size(), 0);

    // Stalled frame: start + 5 data bits, then nothing
    push_err();
    fb = frame(8'h1C, 1'b0);
    send_bits(fb, 5);
    ps2_dat = fb[5];
    cyc(H);
    ps2_clk = 1'b0;
    first = -1;
    for (int k = 1; k <= 2 + FL + TO + 10; k++) begin
      @(negedge clock);
      if (k == H) ps2_clk = 1'b1;
      if (bus.frame_error && first < 0) first = k;
    end
    ps2_dat = 1'b1;
    chk("timeout_cycle", first, 2 + FL + TO);
    cyc(H);
    push_code(8'h1C, 1'b0, 1'b1);
    send(8'hF0); send(8'h1C);

    // Short glitch with data low: ignored, next frame decodes cleanly
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    cyc(FL - 1);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(TO + 50);
    chk("short_glitch_quiet", exp_q.size(), 0);
    push_code(8'h1C, 1'b0, 1'b0);
    send(8'h1C);

    // Glitch of FILTER_LEN cycles with data low: taken as a start bit -> timeout
    push_err();
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    cyc(FL);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(TO + 50);
    chk("long_glitch_drain", exp_q.size(), 0);

    // Hold both keys, then reset in the middle of a frame
    push_code(8'h75, 1'b1, 1'b0);
    send(8'hE0); send(8'h75);
    chk("both_keys", bus.key_state, 2'b11);
    send_bits(frame(8'h33, 1'b0), 3);
    reset = 1'b1;
    cyc(1);
    chk_all_zero("midreset");
    reset = 1'b0;
    cyc(10);
    push_code(8'h75, 1'b1, 1'b0);
    send(8'hE0); send(8'h75);
    chk("post_reset_keys", bus.key_state, 2'b10);

    cyc(20);
    chk("queue_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
